// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared types and the rotating-priority search for the round-robin arbiter.
// The search is sized for the largest supported requester count; callers cast to their own widths.
package arb_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

    localparam int unsigned ARB_MAX_REQ   = 16;
    localparam int unsigned ARB_MAX_IDX_W = 4;

    // Scan req starting at ptr, wrapping at n; ptr < n is assumed.
    function automatic logic [ARB_MAX_IDX_W-1:0] rr_pick(
        input logic [ARB_MAX_REQ-1:0]   req,
        input logic [ARB_MAX_IDX_W-1:0] ptr,
        input int unsigned              n
    );
        logic [ARB_MAX_IDX_W-1:0] win;
        logic                     found;
        int unsigned              c;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < ARB_MAX_REQ; k++) begin
            if (k < n) begin
                c = k + 32'(ptr);
                if (c >= n) begin
                    c = c - n;
                end
                if (!found && req[c[ARB_MAX_IDX_W-1:0]]) begin
                    win   = c[ARB_MAX_IDX_W-1:0];
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter_bin_to_onehot.sv
// Combinational binary-to-one-hot decoder; indices beyond ONE_HOT_W decode to all zeros.
module bin_to_onehot #(
    parameter int unsigned BIN_W     = 2,
    parameter int unsigned ONE_HOT_W = 4
) (
    input  logic [BIN_W-1:0]     bin_i,
    output logic [ONE_HOT_W-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (32'(bin_i) < ONE_HOT_W) begin
            onehot_o[bin_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot grant, binary owner index and an optional hold limit.
// One IDLE cycle always separates consecutive grants.
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_REQ),
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               done_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o,
    output logic               preempt_o
);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   hold_cnt_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               valid_q;
    logic               preempt_q;

    logic [IDX_W-1:0]   win_idx_d;
    logic [NUM_REQ-1:0] win_onehot_d;
    logic [IDX_W-1:0]   ptr_d;
    logic               owner_req;
    logic               hold_hit;
    logic               release_grant;

    assign win_idx_d = IDX_W'(rr_pick(ARB_MAX_REQ'(req_i), ARB_MAX_IDX_W'(ptr_q), NUM_REQ));

    bin_to_onehot #(
        .BIN_W     (IDX_W),
        .ONE_HOT_W (NUM_REQ)
    ) u_dec (
        .bin_i    (win_idx_d),
        .onehot_o (win_onehot_d)
    );

    assign owner_req     = req_i[idx_q];
    assign hold_hit      = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    assign release_grant = done_i || !owner_req || hold_hit;
    // The last owner becomes the lowest priority on the next search.
    assign ptr_d         = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        idx_q      <= win_idx_d;
                        gnt_q      <= win_onehot_d;
                        valid_q    <= 1'b1;
                        hold_cnt_q <= '0;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        gnt_q     <= '0;
                        valid_q   <= 1'b0;
                        ptr_q     <= ptr_d;
                        state_q   <= IDLE;
                        preempt_q <= hold_hit && !done_i && owner_req;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = valid_q;
    assign preempt_o   = preempt_q;

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that shares one resource between NUM_REQ requesters.
- Selects a winner index in binary and drives a registered one-hot grant using the team's binary-to-one-hot decode.
- Holds the grant until the owner signals done, drops its request, or exceeds a hold limit.
- Sits in front of any shared datapath: the one-hot grant drives its input mux select, and the binary index tags the transaction.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- IDX_W, $clog2(NUM_REQ), width of the binary grant index.
- MAX_HOLD, 8, maximum consecutive GRANT cycles before forced release; 0 disables the limit.
- CNT_W, 8, hold counter width; must satisfy MAX_HOLD < 2**CNT_W.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester request level.
- done_i  input  1  current owner finished; sampled only in GRANT.
- gnt_o  output  NUM_REQ  registered one-hot grant; all zeros when idle.
- gnt_idx_o  output  IDX_W  binary index of the owner; valid only when gnt_valid_o=1.
- gnt_valid_o  output  1  high while any grant is held.
- preempt_o  output  1  one-cycle pulse when the grant is removed by the hold limit.

Behaviour:
Interface:
- One clock (clk); reset is synchronous and active-high.

Reset:
- state=IDLE, ptr=0, hold_cnt=0.
- gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, preempt_o=0.
- Reset asserted mid-GRANT clears everything on that edge; no preempt pulse.

States:
- IDLE: if |req_i at an edge, choose winner w = first set bit scanning ptr, ptr+1, ... wrapping mod NUM_REQ.
  - On that edge: gnt_idx_o<=w, gnt_o<=onehot(w), gnt_valid_o<=1, hold_cnt<=0, state<=GRANT.
  - If no request, stay in IDLE with outputs zero.
- GRANT: release condition R = done_i | ~req_i[gnt_idx_o] | (MAX_HOLD!=0 & hold_cnt==MAX_HOLD-1).
  - On an edge with R: gnt_o<=0, gnt_valid_o<=0, ptr<=(gnt_idx_o+1) mod NUM_REQ, state<=IDLE.
  - preempt_o<=1 only if the hold limit alone caused release (done_i=0 and req still high).
  - Otherwise: hold_cnt<=hold_cnt+1, and the grant is unchanged.

Latency and throughput:
- Request seen at edge t in IDLE -> gnt_o high from t+1.
- Release seen at edge t -> gnt_o low from t+1.
- Always exactly one IDLE bubble cycle between consecutive grants.

Fairness and wrap:
- ptr wraps from NUM_REQ-1 to 0.
- The last owner has lowest priority next round.
- With all requesters asserted, grants rotate 0,1,2,...,NUM_REQ-1,0.

Boundary cases:
- Simultaneous done_i and hold-limit hit: treated as normal release; preempt_o=0.
- Requests arriving or dropping during GRANT, for non-owners, have no effect until IDLE.
- done_i in IDLE is ignored.
- Preempted requester still requesting is re-queued purely by ptr order; no extra priority.
- MAX_HOLD=1: every grant lasts exactly one cycle.
- MAX_HOLD=0: grant held indefinitely while req stays high and done_i is low.

Invariants:
- gnt_o is always zero or exactly one-hot.
- gnt_o == onehot(gnt_idx_o) whenever gnt_valid_o=1.

Decomposition:
- Package arb_pkg:
  - state enum (IDLE, GRANT).
  - Helper function for rotating priority search: returns the winner index given req and ptr.
- Sub-module bin_to_onehot, parameterized by BIN_W/ONE_HOT_W.
  - Combinationally decodes the next winner index.
  - The arbiter registers its output into gnt_o.

Test Plan:
1. Reset held 3 cycles with req_i=4'b1111 -> gnt_o=0, gnt_valid_o=0; first grant is gnt_o=4'b0001 one cycle after reset deasserts.
2. req_i=4'b1111 constant, done_i pulsed on the 2nd cycle of each grant -> gnt_idx_o sequence 0,1,2,3,0, each with one idle bubble between grants.
3. req_i=4'b0100 only, MAX_HOLD=8, done_i=0 -> grant held 8 cycles; preempt_o pulses once; regranted to 2 after one idle cycle.
4. Owner 1 drops req_i[1] mid-grant -> gnt_o=0 next cycle, preempt_o=0, next winner searched starting from 2.
5. done_i and hold-limit in the same cycle -> release with preempt_o=0.
6. Reset asserted mid-GRANT (owner 3) -> outputs zero next cycle, ptr=0; req_i=4'b1001 then grants 0 first.
